nibble_serial_adder: RTL
========================

Name: nibble_serial_adder

Overview:
Multi-cycle wide-operand adder that feeds the existing 4-bit ripple-carry adder slice (ripple_carry_adder_4bit, ports a, b, cin, sum, cout) one nibble per cycle. It registers the carry between nibbles and assembles the full-width sum. Results are delivered on a valid/ready interface. It is the sequencing stage directly upstream of the 4-bit slice and lets one slice serve operands of any multiple-of-4 width.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
NIBBLES (localparam), WIDTH/4, number of slice passes per operation.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands and cin presented.
in_ready  output  1  block can accept operands.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
in_cin  input  1  carry-in to least-significant nibble.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
out_sum  output  WIDTH  (A + B + cin) mod 2^WIDTH.
out_cout  output  1  carry out of the most-significant nibble.
busy  output  1  high in ADD or DONE.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). While rst_n=0: state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0, busy=0, internal carry/index/operand registers=0.
- Reset mid-operation aborts the operation immediately. No partial result is ever presented.
- Exactly one ripple_carry_adder_4bit instance is used. Its a/b inputs come from nibble[idx] of the captured operands, and its cin comes from the carry register.
- FSM states: IDLE, ADD, DONE.
- IDLE: in_ready=1. On a rising edge with in_valid=1, capture in_a, in_b, carry<=in_cin, idx<=0, then go to ADD.
- ADD: in_ready=0, busy=1. Each cycle:
  - sum nibble[idx] <= slice sum.
  - carry <= slice cout.
  - idx <= idx+1.
- ADD exit: on the cycle where idx==NIBBLES-1, also out_cout <= slice cout, and go to DONE.
- Result staging: the sum register becomes visible on out_sum only on entry to DONE. Between operations out_sum holds the previous result.
- DONE: out_valid=1; out_sum and out_cout are stable until the handshake. On an edge with out_ready=1, clear out_valid and go to IDLE. out_sum/out_cout keep their values.
- Latency: accept edge at T gives out_valid=1 after edge T+NIBBLES (NIBBLES clock cycles). WIDTH=16 gives 4 cycles; WIDTH=4 gives 1 cycle.
- Throughput: at most one operation per NIBBLES+2 cycles.
- in_ready is high only in IDLE. in_valid in ADD/DONE is ignored and its operands are not captured. Input changes after capture do not affect the result in progress.
- Arithmetic: carries propagate nibble to nibble, LSB first. The result equals the exact WIDTH-bit sum plus cin; out_cout is bit WIDTH of the full sum.
- Back-pressure: out_ready=0 holds DONE indefinitely with outputs unchanged.
- out_ready while not in DONE has no effect.
- The idx counter is $clog2(NIBBLES) bits wide, minimum 1, and never exceeds NIBBLES-1.

Test Plan:
- WIDTH=16, A=0x1234, B=0x4321, cin=0 -> out_sum=0x5555, out_cout=0, out_valid rises exactly 4 cycles after the accept edge.
- A=0xFFFF, B=0x0001, cin=0 -> out_sum=0x0000, out_cout=1 (carry ripples through all four nibbles). A=0xFFFF, B=0xFFFF, cin=1 -> 0xFFFF, cout=1.
- A=0x0F0F, B=0x00F1, cin=1 -> 0x1001, cout=0. While busy, drive in_valid=1 with A=0xAAAA -> in_ready=0, the operands are ignored, and the result is unchanged.
- Hold out_ready=0 for 10 cycles in DONE -> out_valid, out_sum and out_cout stay stable. Assert out_ready -> out_valid falls next edge and in_ready=1.
- Assert rst_n=0 two cycles into ADD -> all outputs go to 0 asynchronously (no clock edge needed) and in_ready=1. After release, A=0x0001, B=0x0002 -> 0x0003, cout=0.
- WIDTH=4 build, A=0xF, B=0x1, cin=0 -> out_sum=0x0, out_cout=1, one-cycle latency. Also run 200 random A/B/cin cases against a reference sum with random out_ready stalls.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Wide-operand adder that reuses one 4-bit ripple-carry slice, one nibble per cycle,
// LSB first, and delivers the registered result over a valid/ready handshake.

module ripple_carry_adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] w_c;

    // Four chained full adders
    always_comb begin
        w_c    = 5'd0;
        w_c[0] = cin;
        sum    = 4'd0;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ w_c[i];
            w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
        cout = w_c[4];
    end
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_sum_acc;
    logic [WIDTH-1:0]  r_out_sum;
    logic              r_carry;
    logic              r_out_cout;
    logic [IDXW-1:0]   r_idx;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_busy;

    logic [3:0]        w_a_nib;
    logic [3:0]        w_b_nib;
    logic [3:0]        w_slice_sum;
    logic              w_slice_cout;
    logic              w_last;
    logic [WIDTH-1:0]  w_sum_next;

    ripple_carry_adder_4bit u_slice (
        .a    (w_a_nib),
        .b    (w_b_nib),
        .cin  (r_carry),
        .sum  (w_slice_sum),
        .cout (w_slice_cout)
    );

    // Select the current operand nibbles and merge the slice result into the accumulator
    always_comb begin
        w_a_nib    = 4'd0;
        w_b_nib    = 4'd0;
        w_sum_next = r_sum_acc;
        for (int n = 0; n < NIBBLES; n++) begin
            if (r_idx == IDXW'(n)) begin
                w_a_nib                 = r_a[n*4 +: 4];
                w_b_nib                 = r_b[n*4 +: 4];
                w_sum_next[n*4 +: 4]    = w_slice_sum;
            end else begin
                w_sum_next[n*4 +: 4]    = r_sum_acc[n*4 +: 4];
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        w_last       = (r_idx == IDX_LAST);
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_next = ST_ADD;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ADD: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_ADD;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register and registered handshake flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_in_ready  <= (w_state_next == ST_IDLE);
            r_out_valid <= (w_state_next == ST_DONE);
            r_busy      <= (w_state_next != ST_IDLE);
        end
    end

    // Operand capture, nibble sequencing and result staging
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_sum_acc  <= '0;
            r_out_sum  <= '0;
            r_carry    <= 1'b0;
            r_out_cout <= 1'b0;
            r_idx      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a       <= in_a;
                        r_b       <= in_b;
                        r_carry   <= in_cin;
                        r_idx     <= '0;
                        r_sum_acc <= '0;
                    end
                end
                ST_ADD: begin
                    r_sum_acc <= w_sum_next;
                    r_carry   <= w_slice_cout;
                    if (w_last) begin
                        r_out_sum  <= w_sum_next;
                        r_out_cout <= w_slice_cout;
                        r_idx      <= '0;
                    end else begin
                        r_idx      <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign out_sum   = r_out_sum;
    assign out_cout  = r_out_cout;
endmodule
